mac_combine_acc: RTL and testbench

Parametrised partial-product combiner and accumulator that sits between the multiplier array and the tile output. It generalises the fixed 4-lane single/dual/quad combiner to `LANES` lanes and any power-of-two group size. It adds true multi-lane carry propagation in accumulate mode, a valid/ready handshake, packet-delimited accumulation with init reload, and wrap/saturate overflow handling.

---
 rtl/mac_pkg.sv | 32 +++
 rtl/mac_lane_combine.sv | 42 ++++
 rtl/mac_combine_acc.sv | 165 ++++++++++++++++
 tb/tb_mac_combine_acc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the partial-product combiner/accumulator:
// state encoding, default widths and group-size helpers.
package mac_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_MIN_WIDTH = 8;
  localparam int unsigned DEF_INT_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH = 32;

  // Requested group log2 is clamped so a group never spans more than all lanes.
  function automatic int clamp_log2(input int req, input int max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

  function automatic int grp_mask(input int log2_g);
    return (1 << log2_g) - 1;
  endfunction

  function automatic bit is_grp_base(input int lane, input int mask);
    return (lane & mask) == 0;
  endfunction

  function automatic bit is_grp_top(input int lane, input int mask);
    return (lane & mask) == mask;
  endfunction

endpackage

// File: rtl/mac_lane_combine.sv
// Shift-add of the partials of each G-lane group into one G*ACC_WIDTH value,
// with a carry-out flag reported on the group's top lane.
module mac_lane_combine
  import mac_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned G         = 1,
  parameter int unsigned MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int unsigned INT_WIDTH = DEF_INT_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [LANES*INT_WIDTH-1:0] partials,
  output logic [LANES*ACC_WIDTH-1:0] comb,
  output logic [LANES-1:0]           ovf
);

  localparam int unsigned NGROUPS = LANES / G;
  localparam int unsigned GW      = G * ACC_WIDTH;
  // Headroom above GW so an out-of-range combine is seen rather than lost.
  localparam int unsigned CW      = GW + INT_WIDTH + (G - 1) * MIN_WIDTH + G;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_grp
      logic [CW-1:0] sum;

      always_comb begin
        sum = '0;
        for (int k = 0; k < G; k++) begin
          sum = sum + (CW'(partials[(gi*G+k)*INT_WIDTH +: INT_WIDTH]) << (k * MIN_WIDTH));
        end
      end

      assign comb[gi*GW +: GW] = sum[GW-1:0];

      for (gj = 0; gj < G; gj++) begin : g_flag
        assign ovf[gi*G+gj] = (gj == G - 1) ? (|sum[CW-1:GW]) : 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/mac_combine_acc.sv
// Combiner + packet accumulator with lane-spanning carries, init preload,
// wrap/saturate overflow handling and a one-stage valid/ready output register.
module mac_combine_acc
  import mac_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int unsigned INT_WIDTH = DEF_INT_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(LANES):0]     cfg_group_log2,
  input  logic                       cfg_acc_en,
  input  logic                       cfg_sat,
  input  logic                       init_load,
  input  logic [LANES*ACC_WIDTH-1:0] init_val,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*INT_WIDTH-1:0] in_partials,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out_data,
  output logic [LANES-1:0]           out_overflow
);

  localparam int unsigned LOG2_LANES = $clog2(LANES);
  localparam int unsigned NUM_G      = LOG2_LANES + 1;
  localparam int unsigned DW         = LANES * ACC_WIDTH;

  state_t                 state_reg, state_next;
  logic [LOG2_LANES:0]    cfg_glog2_reg;
  logic                   cfg_sat_reg;
  logic [DW-1:0]          acc_reg, init_reg, out_data_reg;
  logic [LANES-1:0]       sticky_reg, out_ovf_reg;
  logic                   out_valid_reg;

  logic [DW-1:0]          comb_all [NUM_G];
  logic [LANES-1:0]       covf_all [NUM_G];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_G; gi++) begin : g_comb
      mac_lane_combine #(
        .LANES    (LANES),
        .G        (1 << gi),
        .MIN_WIDTH(MIN_WIDTH),
        .INT_WIDTH(INT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_comb (
        .partials(in_partials),
        .comb    (comb_all[gi]),
        .ovf     (covf_all[gi])
      );
    end
  endgenerate

  logic                busy, in_fire, preload, eff_acc, eff_sat;
  logic [LOG2_LANES:0] eff_glog2;
  int                  g_sel, g_mask;
  logic [DW-1:0]       comb_sel, base, result;
  logic [LANES-1:0]    covf_sel, flags, grp_flag;
  logic                carry, cur;
  logic [ACC_WIDTH:0]  lsum;

  assign busy      = (state_reg == ST_BUSY);
  assign in_ready  = !out_valid_reg || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign preload   = !busy && init_load;
  // A packet in flight keeps the configuration captured on its first beat.
  assign eff_acc   = busy ? 1'b1 : cfg_acc_en;
  assign eff_sat   = busy ? cfg_sat_reg : cfg_sat;
  assign eff_glog2 = busy ? cfg_glog2_reg : cfg_group_log2;

  always_comb begin
    g_sel    = clamp_log2(int'(eff_glog2), LOG2_LANES);
    g_mask   = grp_mask(g_sel);
    comb_sel = '0;
    covf_sel = '0;
    for (int j = 0; j < NUM_G; j++) begin
      if (g_sel == j) begin
        comb_sel = comb_all[j];
        covf_sel = covf_all[j];
      end
    end
    base     = !eff_acc ? '0 : (preload ? init_val : acc_reg);
    carry    = 1'b0;
    lsum     = '0;
    result   = '0;
    flags    = '0;
    grp_flag = '0;
    cur      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lsum = {1'b0, base[i*ACC_WIDTH +: ACC_WIDTH]} + {1'b0, comb_sel[i*ACC_WIDTH +: ACC_WIDTH]}
           + {{ACC_WIDTH{1'b0}}, (is_grp_base(i, g_mask) ? 1'b0 : carry)};
      carry = lsum[ACC_WIDTH];
      result[i*ACC_WIDTH +: ACC_WIDTH] = lsum[ACC_WIDTH-1:0];
      if (is_grp_top(i, g_mask)) begin
        flags[i] = carry || covf_sel[i] || (eff_acc && sticky_reg[i]);
      end
    end
    // Spread each group's top-lane flag down over the whole group.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (is_grp_top(i, g_mask)) cur = flags[i];
      grp_flag[i] = cur;
      if (eff_sat && cur) result[i*ACC_WIDTH +: ACC_WIDTH] = '1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_fire && eff_acc && !in_last) state_next = ST_BUSY;
      ST_BUSY: if (in_fire && in_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_glog2_reg <= '0;
      cfg_sat_reg   <= 1'b0;
      acc_reg       <= '0;
      init_reg      <= '0;
      sticky_reg    <= '0;
      out_data_reg  <= '0;
      out_ovf_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (preload) init_reg <= init_val;
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      if (in_fire && !busy) begin
        cfg_glog2_reg <= cfg_group_log2;
        cfg_sat_reg   <= cfg_sat;
      end
      if (in_fire && (!eff_acc || in_last)) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result;
        out_ovf_reg   <= flags;
      end
      if (in_fire && eff_acc) begin
        if (in_last) begin
          acc_reg    <= preload ? init_val : init_reg;
          sticky_reg <= '0;
        end else begin
          acc_reg    <= result;
          sticky_reg <= flags;
        end
      end else if (preload) begin
        acc_reg <= init_val;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_overflow = out_ovf_reg;

endmodule

// File: tb/tb_mac_combine_acc.sv
// Directed-vector bench for mac_combine_acc (LANES=4, 8/16/32 widths).
module tb_mac_combine_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   cfg_group_log2;
  logic         cfg_acc_en, cfg_sat, init_load;
  logic [127:0] init_val;
  logic         in_valid, in_ready, in_last;
  logic [63:0]  in_partials;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_combine_acc #(
    .LANES(4), .MIN_WIDTH(8), .INT_WIDTH(16), .ACC_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_group_log2(cfg_group_log2),
    .cfg_acc_en    (cfg_acc_en),
    .cfg_sat       (cfg_sat),
    .init_load     (init_load),
    .init_val      (init_val),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_partials   (in_partials),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_overflow  (out_overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called on a negedge; presents one beat for exactly one rising edge.
  task automatic drive_beat(input logic [63:0] parts, input logic last,
                            input logic ld, input logic [127:0] iv);
    in_partials = parts;
    in_last     = last;
    init_load   = ld;
    init_val    = iv;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    init_load = 1'b0;
  endtask

  task automatic do_init(input logic [127:0] iv);
    init_load = 1'b1;
    init_val  = iv;
    @(negedge clk);
    init_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_group_log2 = '0; cfg_acc_en = 1'b0; cfg_sat = 1'b0;
    init_load = 1'b0; init_val = '0; in_valid = 1'b0; in_last = 1'b0;
    in_partials = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_ovf", out_overflow, 4'd0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Pass mode, G=1
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, '0);
    chk("p1_valid", out_valid, 1'b1);
    chk("p1_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("p1_ovf", out_overflow, 4'd0);

    // Pass mode, G=4, then an out-of-range group code clamped to G=4
    cfg_group_log2 = 3'd2;
    drive_beat({4{16'hFFFF}}, 1'b0, 1'b0, '0);
    chk("p4_data", out_data, {32'd0, 32'd0, 32'h0000_0100, 32'hFFFF_FEFF});
    cfg_group_log2 = 3'd3;
    drive_beat({4{16'hFFFF}}, 1'b0, 1'b0, '0);
    chk("p4clamp_data", out_data, {32'd0, 32'd0, 32'h0000_0100, 32'hFFFF_FEFF});
    @(negedge clk);
    chk("p_idle_valid", out_valid, 1'b0);

    // Acc G=2: carry crosses from lane0 into lane1, then preload reload
    cfg_acc_en = 1'b1; cfg_group_log2 = 3'd1; cfg_sat = 1'b0;
    do_init({32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF});
    drive_beat({16'd0, 16'd0, 16'd0, 16'd1}, 1'b1, 1'b0, '0);
    chk("a2_data", out_data, {32'd0, 32'd0, 32'd1, 32'd0});
    chk("a2_ovf", out_overflow, 4'd0);
    drive_beat(64'd0, 1'b1, 1'b0, '0);
    chk("a2_reload", out_data, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF});

    // Three-beat packet; cfg changes mid-packet must be ignored
    cfg_group_log2 = 3'd0;
    do_init('0);
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, '0);
    chk("a3_b1_valid", out_valid, 1'b0);
    cfg_acc_en = 1'b0; cfg_group_log2 = 3'd2;
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, '0);
    chk("a3_b2_valid", out_valid, 1'b0);
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0, '0);
    chk("a3_valid", out_valid, 1'b1);
    chk("a3_data", out_data, {32'd12, 32'd9, 32'd6, 32'd3});

    // Overflow G=1 with init_load on the same beat: saturate, then wrap
    cfg_acc_en = 1'b1; cfg_group_log2 = 3'd0; cfg_sat = 1'b1;
    drive_beat({48'd0, 16'h0020}, 1'b1, 1'b1, {96'd0, 32'hFFFF_FFF0});
    chk("sat_data", out_data, {96'd0, 32'hFFFF_FFFF});
    chk("sat_ovf", out_overflow, 4'b0001);
    cfg_sat = 1'b0;
    drive_beat({48'd0, 16'h0020}, 1'b1, 1'b1, {96'd0, 32'hFFFF_FFF0});
    chk("wrap_data", out_data, {96'd0, 32'h0000_0010});
    chk("wrap_ovf", out_overflow, 4'b0001);

    // Saturated group holds and the flag stays sticky across beats
    cfg_sat = 1'b1;
    drive_beat({48'd0, 16'h0020}, 1'b0, 1'b1, {96'd0, 32'hFFFF_FFF0});
    drive_beat(64'd0, 1'b1, 1'b0, '0);
    chk("hold_data", out_data, {96'd0, 32'hFFFF_FFFF});
    chk("hold_ovf", out_overflow, 4'b0001);

    // Backpressure in pass mode
    cfg_acc_en = 1'b0; cfg_sat = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    drive_beat({16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 1'b0, '0);
    in_partials = {16'd8, 16'd7, 16'd6, 16'd5};
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_data", out_data, {32'd40, 32'd30, 32'd20, 32'd10});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_data", out_data, {32'd8, 32'd7, 32'd6, 32'd5});
    @(negedge clk);
    chk("bp_drain", out_valid, 1'b0);

    // Asynchronous reset drops a pending output without a clock edge
    out_ready = 1'b0;
    drive_beat({48'd0, 16'd9}, 1'b0, 1'b0, '0);
    chk("rs_pending", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rs_async_valid", out_valid, 1'b0);
    chk("rs_async_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    // Reset mid-packet discards the partial sum and the preload
    cfg_acc_en = 1'b1;
    drive_beat({48'd0, 16'd7}, 1'b0, 1'b0, '0);
    drive_beat({48'd0, 16'd7}, 1'b0, 1'b0, '0);
    #2 rst = 1'b0;
    #1;
    chk("rm_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_beat({48'd0, 16'd5}, 1'b1, 1'b0, '0);
    chk("rm_after_valid", out_valid, 1'b1);
    chk("rm_after_data", out_data, {96'd0, 32'd5});
    chk("rm_after_ovf", out_overflow, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
